// File: rtl/wb_merge_pkg.sv
// -----------------------------------------------------------------------------
// wb_merge_pkg
// Shared types for the write-back merge unit: register-id range, the grant
// source encoding used by the arbiter, and a pointer-width helper.
// Imported by wb_fifo and wb_merge.
// -----------------------------------------------------------------------------
package wb_merge_pkg;

  // Register-file address width (32 architectural registers, x0 hardwired).
  localparam int REGID_W = 5;

  typedef logic [REGID_W-1:0] regid_t;

  localparam regid_t REG_ZERO = '0;

  // Which requester owns the register-file write port in a given cycle.
  typedef enum logic [1:0] {
    GRANT_NONE = 2'd0,
    GRANT_PIPE = 2'd1,
    GRANT_FIFO = 2'd2
  } grant_e;

  // Width of an index/pointer over n items; never narrower than one bit so a
  // single-entry range still yields a legal vector.
  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage : wb_merge_pkg

// File: rtl/wb_fifo.sv
// -----------------------------------------------------------------------------
// wb_fifo
// Single-clock, DEPTH-entry FIFO with count-based full/empty flags. Holds the
// pending results of one long-latency source until the merge arbiter pops them.
//
// Parameters
//   WIDTH   entry width in bits
//   DEPTH   number of entries (power of two, >= 2)
//
// Ports
//   clk       clock
//   rst       synchronous active-high reset (clears pointers and count)
//   push_i    write wdata_i at the tail (caller guarantees !full_o)
//   wdata_i   entry to store
//   pop_i     drop the head entry (caller guarantees !empty_o)
//   rdata_o   head entry, valid while !empty_o
//   full_o    occupancy == DEPTH, from registered count only
//   empty_o   occupancy == 0, from registered count only
// -----------------------------------------------------------------------------
module wb_fifo
  import wb_merge_pkg::*;
#(
  parameter int WIDTH = 37,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = ptr_w(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  // Pointers wrap naturally because DEPTH is a power of two.
  // NOTE: every variable written in an always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_i)  rd_ptr_d = rd_ptr_q + AW'(1);
    // Simultaneous push and pop leaves occupancy unchanged.
    unique case ({push_i, pop_i})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, independent of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; the cleared count makes
  // old contents unreachable, and leaving it out keeps it a plain RAM.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);

endmodule : wb_fifo

// File: rtl/wb_merge.sv
// -----------------------------------------------------------------------------
// wb_merge
// Merges the in-order pipeline's register write with results returned by up to
// four long-latency sources onto a single register-file write port. The
// pipeline always wins; otherwise one non-empty source FIFO is popped. The
// granted write is registered and appears on wb_reg_* one cycle later.
// If FIFOs sit unserved for STARVE_LIMIT busy cycles, wb_stall_req asks the
// pipeline for a bubble until a FIFO is finally granted.
//
// Build option
//   WB_MERGE_RR_EN  defined: round-robin among FIFOs (pointer -> granted+1)
//                   undefined: fixed priority, lowest index first
//
// Parameters
//   XLEN          register data width
//   NUM_SRC       number of long-latency sources (1..4)
//   DEPTH         entries per source FIFO (power of two, >= 2)
//   STARVE_LIMIT  unserved busy cycles before a stall is requested
//
// Ports
//   clk, rst               clock, synchronous active-high reset
//   pipe_reg_write/regid/writedata   pipeline write request
//   src_valid/src_ready    per-source handshake
//   src_regid, src_data    flattened per-source destination and data
//   wb_reg_write/regid/writedata     registered register-file write
//   wb_stall_req           registered request for one pipeline bubble
//   wb_busy                any source FIFO holds an entry
// -----------------------------------------------------------------------------
module wb_merge
  import wb_merge_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int NUM_SRC      = 2,
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    pipe_reg_write,
  input  logic [REGID_W-1:0]      pipe_reg_regid,
  input  logic [XLEN-1:0]         pipe_reg_writedata,
  input  logic [NUM_SRC-1:0]      src_valid,
  output logic [NUM_SRC-1:0]      src_ready,
  input  logic [REGID_W*NUM_SRC-1:0] src_regid,
  input  logic [XLEN*NUM_SRC-1:0] src_data,
  output logic                    wb_reg_write,
  output logic [REGID_W-1:0]      wb_reg_regid,
  output logic [XLEN-1:0]         wb_reg_writedata,
  output logic                    wb_stall_req,
  output logic                    wb_busy
);

  localparam int SRC_W = ptr_w(NUM_SRC);
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  typedef struct packed {
    regid_t          regid;
    logic [XLEN-1:0] data;
  } entry_t;

  typedef struct packed {
    logic            write;
    regid_t          regid;
    logic [XLEN-1:0] data;
  } wb_t;

  // ---------------------------------------------------------------------------
  // Source FIFOs
  // ---------------------------------------------------------------------------
  entry_t             push_entry [NUM_SRC];
  entry_t             fifo_rdata [NUM_SRC];
  logic [NUM_SRC-1:0] fifo_push;
  logic [NUM_SRC-1:0] fifo_pop;
  logic [NUM_SRC-1:0] fifo_full;
  logic [NUM_SRC-1:0] fifo_empty;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    assign push_entry[g].regid = src_regid[REGID_W*g +: REGID_W];
    assign push_entry[g].data  = src_data[XLEN*g +: XLEN];

    // Ready depends only on registered occupancy, so a pop of a full FIFO
    // frees the slot for the source no earlier than the next cycle.
    assign src_ready[g] = !fifo_full[g];

    // Writes to x0 complete the handshake but are never stored.
    assign fifo_push[g] = src_valid[g] && src_ready[g] &&
                          (push_entry[g].regid != REG_ZERO);

    wb_fifo #(
      .WIDTH ($bits(entry_t)),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (fifo_push[g]),
      .wdata_i (push_entry[g]),
      .pop_i   (fifo_pop[g]),
      .rdata_o (fifo_rdata[g]),
      .full_o  (fifo_full[g]),
      .empty_o (fifo_empty[g])
    );
  end : g_src

  assign wb_busy = |(~fifo_empty);

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  logic             pipe_occupied;
  logic             fifo_cand_vld;
  logic [SRC_W-1:0] fifo_cand_idx;
  grant_e           grant_sel;

  assign pipe_occupied = pipe_reg_write && (pipe_reg_regid != REG_ZERO);

`ifdef WB_MERGE_RR_EN
  logic [SRC_W-1:0] rr_ptr_q, rr_ptr_d;

  // Index k positions after base, modulo NUM_SRC.
  function automatic logic [SRC_W-1:0] rot_idx(input logic [SRC_W-1:0] base,
                                               input int k);
    int s;
    s = int'(base) + k;
    if (s >= NUM_SRC) s = s - NUM_SRC;
    return SRC_W'(s);
  endfunction

  // Scan from the far end toward the pointer so the last hit is the first
  // non-empty FIFO at or after rr_ptr_q.
  always_comb begin
    fifo_cand_vld = 1'b0;
    fifo_cand_idx = '0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      if (!fifo_empty[rot_idx(rr_ptr_q, k)]) begin
        fifo_cand_vld = 1'b1;
        fifo_cand_idx = rot_idx(rr_ptr_q, k);
      end
    end
  end
`else
  // Fixed priority: the last hit of a downward scan is the lowest index.
  always_comb begin
    fifo_cand_vld = 1'b0;
    fifo_cand_idx = '0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      if (!fifo_empty[k]) begin
        fifo_cand_vld = 1'b1;
        fifo_cand_idx = SRC_W'(k);
      end
    end
  end
`endif

  always_comb begin
    grant_sel = GRANT_NONE;
    if (pipe_occupied)      grant_sel = GRANT_PIPE;
    else if (fifo_cand_vld) grant_sel = GRANT_FIFO;
  end

  always_comb begin
    fifo_pop = '0;
    if (grant_sel == GRANT_FIFO) fifo_pop[fifo_cand_idx] = 1'b1;
  end

`ifdef WB_MERGE_RR_EN
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (grant_sel == GRANT_FIFO) begin
      rr_ptr_d = (fifo_cand_idx == SRC_W'(NUM_SRC - 1)) ? '0
                                                        : fifo_cand_idx + SRC_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) rr_ptr_q <= '0;
    else     rr_ptr_q <= rr_ptr_d;
  end
`endif

  // ---------------------------------------------------------------------------
  // Registered write-back port
  // ---------------------------------------------------------------------------
  wb_t wb_q, wb_d;

  always_comb begin
    wb_d = '0;
    unique case (grant_sel)
      GRANT_PIPE: begin
        wb_d.write = 1'b1;
        wb_d.regid = pipe_reg_regid;
        wb_d.data  = pipe_reg_writedata;
      end
      GRANT_FIFO: begin
        wb_d.write = 1'b1;
        wb_d.regid = fifo_rdata[fifo_cand_idx].regid;
        wb_d.data  = fifo_rdata[fifo_cand_idx].data;
      end
      default: wb_d = '0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Starvation tracking
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] starve_q, starve_d;
  logic             stall_q, stall_d;

  // Counts busy cycles in which no FIFO was served. It saturates at the limit,
  // so while the pipeline keeps winning under an active stall request the
  // count simply holds; any FIFO grant clears it.
  always_comb begin
    starve_d = starve_q;
    if (grant_sel == GRANT_FIFO)          starve_d = '0;
    else if (wb_busy && starve_q != CNT_MAX) starve_d = starve_q + CNT_W'(1);
    // Stall is raised together with the count reaching the limit and stays up
    // until the grant that clears the count.
    stall_d = (starve_d == CNT_MAX);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_q     <= '0;
      starve_q <= '0;
      stall_q  <= 1'b0;
    end else begin
      wb_q     <= wb_d;
      starve_q <= starve_d;
      stall_q  <= stall_d;
    end
  end

  assign wb_reg_write     = wb_q.write;
  assign wb_reg_regid     = wb_q.regid;
  assign wb_reg_writedata = wb_q.data;
  assign wb_stall_req     = stall_q;

endmodule : wb_merge

// File: tb/tb_wb_merge.sv
// -----------------------------------------------------------------------------
// tb_wb_merge
// Self-checking bench for wb_merge with default parameters (XLEN=32,
// NUM_SRC=2, DEPTH=2, STARVE_LIMIT=8). A queue-based reference model predicts
// the register-file writes, source readiness, busy and stall outputs.
// Directed scenarios run first, then randomized traffic with occasional resets.
// -----------------------------------------------------------------------------
module tb_wb_merge;

  localparam int XLEN  = 32;
  localparam int NSRC  = 2;
  localparam int DEPTH = 2;
  localparam int LIMIT = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              pipe_reg_write;
  logic [4:0]        pipe_reg_regid;
  logic [XLEN-1:0]   pipe_reg_writedata;
  logic [NSRC-1:0]   src_valid;
  logic [NSRC-1:0]   src_ready;
  logic [5*NSRC-1:0] src_regid;
  logic [XLEN*NSRC-1:0] src_data;
  logic              wb_reg_write;
  logic [4:0]        wb_reg_regid;
  logic [XLEN-1:0]   wb_reg_writedata;
  logic              wb_stall_req;
  logic              wb_busy;

  wb_merge #(
    .XLEN         (XLEN),
    .NUM_SRC      (NSRC),
    .DEPTH        (DEPTH),
    .STARVE_LIMIT (LIMIT)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .pipe_reg_write     (pipe_reg_write),
    .pipe_reg_regid     (pipe_reg_regid),
    .pipe_reg_writedata (pipe_reg_writedata),
    .src_valid          (src_valid),
    .src_ready          (src_ready),
    .src_regid          (src_regid),
    .src_data           (src_data),
    .wb_reg_write       (wb_reg_write),
    .wb_reg_regid       (wb_reg_regid),
    .wb_reg_writedata   (wb_reg_writedata),
    .wb_stall_req       (wb_stall_req),
    .wb_busy            (wb_busy)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string tag, input logic [63:0] act,
                       input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s @%0t: got %0h, expected %0h", tag, $time, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: one queue of pending {regid,data} per source
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic [4:0]      id;
    logic [XLEN-1:0] d;
  } ent_t;

  ent_t            mq [NSRC][$];
  int              m_starve;
  int              m_rr;
  logic            exp_write;
  logic [4:0]      exp_id;
  logic [XLEN-1:0] exp_data;
  logic [NSRC-1:0] exp_ready;
  logic            exp_busy;
  logic            exp_stall;

  task automatic model_reset();
    for (int i = 0; i < NSRC; i++) mq[i].delete();
    m_starve  = 0;
    m_rr      = 0;
    exp_write = 1'b0;
    exp_id    = '0;
    exp_data  = '0;
    exp_ready = '1;
    exp_busy  = 1'b0;
    exp_stall = 1'b0;
  endtask

  // Advance the model by one clock using the inputs about to be sampled.
  task automatic model_step(input logic pw, input logic [4:0] pid,
                            input logic [XLEN-1:0] pd, input logic [NSRC-1:0] sv,
                            input logic [5*NSRC-1:0] sid,
                            input logic [XLEN*NSRC-1:0] sd);
    bit busy_now = 1'b0;
    bit served   = 1'b0;
    int pick     = -1;
    bit [NSRC-1:0] room;
    for (int i = 0; i < NSRC; i++) begin
      room[i] = (mq[i].size() < DEPTH);
      if (mq[i].size() != 0) busy_now = 1'b1;
    end
    exp_write = 1'b0;
    exp_id    = '0;
    exp_data  = '0;
    if (pw && pid != 0) begin
      exp_write = 1'b1;
      exp_id    = pid;
      exp_data  = pd;
    end else begin
`ifdef WB_MERGE_RR_EN
      for (int k = 0; k < NSRC; k++)
        if (pick < 0 && mq[(m_rr + k) % NSRC].size() != 0) pick = (m_rr + k) % NSRC;
`else
      for (int k = 0; k < NSRC; k++)
        if (pick < 0 && mq[k].size() != 0) pick = k;
`endif
      if (pick >= 0) begin
        ent_t e = mq[pick].pop_front();
        exp_write = 1'b1;
        exp_id    = e.id;
        exp_data  = e.d;
        served    = 1'b1;
        m_rr      = (pick + 1) % NSRC;
      end
    end
    if (served)                          m_starve = 0;
    else if (busy_now && m_starve < LIMIT) m_starve++;
    exp_stall = (m_starve == LIMIT);
    for (int i = 0; i < NSRC; i++) begin
      ent_t e;
      e.id = sid[5*i +: 5];
      e.d  = sd[XLEN*i +: XLEN];
      if (sv[i] && room[i] && e.id != 0) mq[i].push_back(e);
    end
    exp_busy = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      exp_ready[i] = (mq[i].size() < DEPTH);
      if (mq[i].size() != 0) exp_busy = 1'b1;
    end
  endtask

  // ---------------------------------------------------------------------------
  // One cycle: check the outputs of the previous edge, then apply new inputs
  // ---------------------------------------------------------------------------
  task automatic step(input logic r, input logic pw, input logic [4:0] pid,
                      input logic [XLEN-1:0] pd, input logic [NSRC-1:0] sv,
                      input logic [5*NSRC-1:0] sid, input logic [XLEN*NSRC-1:0] sd);
    @(negedge clk);
    check("wb_reg_write", 64'(wb_reg_write), 64'(exp_write));
    if (exp_write) begin
      check("wb_reg_regid", 64'(wb_reg_regid), 64'(exp_id));
      check("wb_reg_writedata", 64'(wb_reg_writedata), 64'(exp_data));
    end
    check("src_ready", 64'(src_ready), 64'(exp_ready));
    check("wb_busy", 64'(wb_busy), 64'(exp_busy));
    check("wb_stall_req", 64'(wb_stall_req), 64'(exp_stall));
    rst                = r;
    pipe_reg_write     = pw;
    pipe_reg_regid     = pid;
    pipe_reg_writedata = pd;
    src_valid          = sv;
    src_regid          = sid;
    src_data           = sd;
    if (r) model_reset();
    else   model_step(pw, pid, pd, sv, sid, sd);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0, '0, '0, '0);
  endtask

  // Pipeline write to a random non-zero register, no source traffic.
  task automatic pipe_only(input int n);
    for (int i = 0; i < n; i++)
      step(1'b0, 1'b1, 5'($urandom_range(1, 31)), $urandom, '0, '0, '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst                = 1'b1;
    pipe_reg_write     = 1'b0;
    pipe_reg_regid     = '0;
    pipe_reg_writedata = '0;
    src_valid          = '0;
    src_regid          = '0;
    src_data           = '0;
    model_reset();
    repeat (2) @(posedge clk);

    // Pipeline write x5 = 0x11 with nothing pending (first step checks reset).
    step(1'b0, 1'b1, 5'd5, 32'h11, '0, '0, '0);
    idle(2);

    // src0 returns x7 = 0xA while the pipeline is idle.
    step(1'b0, 1'b0, '0, '0, 2'b01, {5'd0, 5'd7}, {32'h0, 32'hA});
    idle(3);

    // x0 results are accepted but discarded.
    step(1'b0, 1'b0, '0, '0, 2'b11, {5'd0, 5'd0}, {32'h5, 32'h6});
    idle(2);

    // Starvation: src0 holds one entry while the pipeline writes every cycle.
    step(1'b0, 1'b1, 5'd3, 32'h33, 2'b01, {5'd0, 5'd9}, {32'h0, 32'h99});
    pipe_only(11);
    idle(3);

    // Fill src0 to DEPTH under a busy pipeline; third valid must stall.
    step(1'b0, 1'b1, 5'd1, 32'h1, 2'b01, {5'd0, 5'd10}, {32'h0, 32'hA0});
    step(1'b0, 1'b1, 5'd2, 32'h2, 2'b01, {5'd0, 5'd11}, {32'h0, 32'hA1});
    step(1'b0, 1'b1, 5'd3, 32'h3, 2'b01, {5'd0, 5'd12}, {32'h0, 32'hA2});
    step(1'b0, 1'b0, '0, '0, 2'b01, {5'd0, 5'd12}, {32'h0, 32'hA2});
    step(1'b0, 1'b0, '0, '0, 2'b01, {5'd0, 5'd12}, {32'h0, 32'hA2});
    idle(4);

    // Both sources loaded under a busy pipeline, then drained.
    step(1'b0, 1'b1, 5'd4, 32'h4, 2'b11, {5'd20, 5'd21}, {32'hB0, 32'hC0});
    step(1'b0, 1'b1, 5'd4, 32'h5, 2'b11, {5'd22, 5'd23}, {32'hB1, 32'hC1});
    idle(6);

    // Reset while both FIFOs are full: nothing stale may come out.
    step(1'b0, 1'b1, 5'd6, 32'h6, 2'b11, {5'd24, 5'd25}, {32'hD0, 32'hE0});
    step(1'b0, 1'b1, 5'd6, 32'h7, 2'b11, {5'd26, 5'd27}, {32'hD1, 32'hE1});
    step(1'b1, 1'b0, '0, '0, '0, '0, '0);
    idle(4);

    // Randomized traffic in alternating heavy/light pipeline phases.
    for (int i = 0; i < 2500; i++) begin
      int unsigned pw_pct = ((i / 60) % 2 == 0) ? 92 : 30;
      logic [5*NSRC-1:0]    sid;
      logic [XLEN*NSRC-1:0] sd;
      logic [NSRC-1:0]      sv;
      logic [4:0]           pid;
      for (int s = 0; s < NSRC; s++) begin
        sid[5*s +: 5]    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        sd[XLEN*s +: XLEN] = $urandom;
        sv[s]            = ($urandom_range(0, 99) < 45);
      end
      pid = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      step(($urandom_range(0, 299) == 0), ($urandom_range(0, 99) < pw_pct),
           pid, $urandom, sv, sid, sd);
    end
    idle(12);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule : tb_wb_merge

// File: doc/wb_merge.md
WB_MERGE -- requirements
Module: wb_merge

Interface
REQ-001 SHALL have parameter XLEN, default 32, register data width.
REQ-002 SHALL have parameter NUM_SRC, default 2, number of long-latency result sources (1..4).
REQ-003 SHALL have parameter DEPTH, default 2, entries per source FIFO (power of 2, >=2).
REQ-004 SHALL have parameter STARVE_LIMIT, default 8, cycles before a stall is requested.
REQ-005 SHALL have port clk, input, 1, the only clock.
REQ-006 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-007 SHALL have port pipe_reg_write, input, 1, in-order pipeline write request.
REQ-008 SHALL have port pipe_reg_regid, input, 5, pipeline destination register.
REQ-009 SHALL have port pipe_reg_writedata, input, XLEN, pipeline write data.
REQ-010 SHALL have port src_valid, input, NUM_SRC, per-source result valid.
REQ-011 SHALL have port src_ready, output, NUM_SRC, per-source accept.
REQ-012 SHALL have port src_regid, input, 5*NUM_SRC, flattened destinations; source i occupies bits [5i+4:5i].
REQ-013 SHALL have port src_data, input, XLEN*NUM_SRC, flattened data; source i occupies bits [XLEN*i+XLEN-1:XLEN*i].
REQ-014 SHALL have port wb_reg_write, output, 1, register-file write enable.
REQ-015 SHALL have port wb_reg_regid, output, 5, register-file write address.
REQ-016 SHALL have port wb_reg_writedata, output, XLEN, register-file write data.
REQ-017 SHALL have port wb_stall_req, output, 1, request one pipeline bubble.
REQ-018 SHALL have port wb_busy, output, 1, any source FIFO non-empty.

Function
REQ-019 SHALL set src_ready[i] = !full[i], computed from registered FIFO occupancy only; a transfer occurs when src_valid[i] && src_ready[i].
REQ-020 SHALL accept a transfer with src_regid == 0 and discard it without storing.
REQ-021 SHALL treat the pipeline slot as occupied only when pipe_reg_write == 1 and pipe_reg_regid != 0.
REQ-022 SHALL grant, each cycle: the pipeline if its slot is occupied; otherwise one non-empty FIFO, which is popped.
REQ-023 SHALL register the granted write; wb_reg_* reflect the grant exactly one cycle later, with wb_reg_write = 0 when nothing was granted.
REQ-024 SHALL use a full FIFO's pop to free space no earlier than the next cycle; push and pop of the same non-full FIFO in one cycle keep occupancy unchanged.
REQ-025 SHALL keep a starvation counter that increments while wb_busy == 1 and no FIFO is granted, saturates at STARVE_LIMIT, and clears on any FIFO grant.
REQ-026 SHALL assert wb_stall_req (registered) in the cycle after the counter reaches STARVE_LIMIT, and hold it until a FIFO grant occurs.
REQ-027 SHALL still give the pipeline priority if pipe_reg_write == 1 while wb_stall_req == 1, and hold the counter; no write is ever dropped.
REQ-028 SHALL preserve per-source FIFO order; no cross-source ordering is guaranteed.

Reset
REQ-029 SHALL, on rst, clear all FIFO pointers and occupancies, the starvation counter and the round-robin pointer, and drive wb_reg_write = 0, wb_reg_regid = 0, wb_reg_writedata = 0, wb_stall_req = 0, wb_busy = 0, src_ready = all ones from the first post-reset cycle.
REQ-030 SHALL discard FIFO contents when rst asserts mid-operation; no write issues in the following cycle.

Configuration
REQ-031 SHALL, with WB_MERGE_RR_EN defined, arbitrate among FIFOs round-robin: the pointer moves to granted index + 1 (mod NUM_SRC) after each FIFO grant.
REQ-032 SHALL, without WB_MERGE_RR_EN, grant the lowest-index non-empty FIFO (fixed priority), with no round-robin pointer.

Structure
REQ-033 SHALL take RF_RANGE and DATA_RANGE from core.svh, and SHALL add an entry typedef {regid, data} for wb_merge to core.svh.
REQ-034 SHALL instantiate one sub-module wb_fifo (single-clock, DEPTH-entry, count-based full/empty) per source.

Verification
REQ-035 SHALL cover: pipe write x5 = 0x11 with no sources pending -> wb_reg_write = 1, regid 5, data 0x11 one cycle later.
REQ-036 SHALL cover: src0 pushes x7 = 0xA while pipe_reg_write = 0 -> x7 = 0xA written two cycles after the push; wb_busy high for one cycle.
REQ-037 SHALL cover: pipe writes every cycle while src0 holds one entry (STARVE_LIMIT = 8) -> wb_stall_req rises on cycle 9; with the pipe idle in the next cycle, src0 is written and wb_stall_req drops.
REQ-038 SHALL cover: src0 pushes DEPTH = 2 entries while the pipe is busy -> src_ready[0] = 0 and a third src_valid stalls; the first pop restores src_ready[0] in the following cycle.
REQ-039 SHALL cover: src0 and src1 both non-empty with the pipe idle -> with WB_MERGE_RR_EN grants alternate 0,1,0,1; without it, all src0 entries are written first.
REQ-040 SHALL cover: rst asserted while both FIFOs are full -> the next cycle shows wb_reg_write = 0, wb_busy = 0, src_ready = 2'b11, and no stale write ever appears.
